// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural order reorder buffer for the R2SDF FFT output stage.
// Two frame banks live in one simple dual-port RAM addressed by {bank, index}.
module fft_bitrev_reorder #(
    parameter int WIDTH = 32,
    parameter int N     = 16,
    parameter int LOG2N = $clog2(N)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] ONE      = LOG2N'(1);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and output data holds while stalled.

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = x[LOG2N-1-i];
        end
        return r;
    endfunction

    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]       full_q, full_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;

    logic             wr_en;
    logic             rd_en;
    logic [LOG2N:0]   wr_addr;
    logic [LOG2N:0]   rd_addr;

    logic [WIDTH-1:0] mem_q [2*N];
    logic [WIDTH-1:0] rdata_q;

    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = rdata_q;

    always_comb begin
        wr_en       = in_valid && in_ready;
        rd_en       = full_q[rd_bank_q] && (!out_valid_q || out_ready);
        wr_addr     = {wr_bank_q, bitrev(wr_cnt_q)};
        rd_addr     = {rd_bank_q, rd_cnt_q};

        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        full_d      = full_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (wr_en) begin
            wr_cnt_d = wr_cnt_q + ONE;
            if (wr_cnt_q == LAST_IDX) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end

        // The read bank is always full and the write bank never is, so the two
        // full-bit updates below always touch different bits.
        if (rd_en) begin
            rd_cnt_d    = rd_cnt_q + ONE;
            out_valid_d = 1'b1;
            out_last_d  = (rd_cnt_q == LAST_IDX);
            if (rd_cnt_q == LAST_IDX) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            full_q      <= 2'b00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Block RAM: contents and read register are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= in_data;
        end
        if (rd_en) begin
            rdata_q <= mem_q[rd_addr];
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder: frames are built in natural order,
// streamed in bit-reversed position order, and expected back in natural order.
module tb_fft_bitrev_reorder;
    localparam int W  = 32;
    localparam int N  = 16;
    localparam int LG = 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_last;

    fft_bitrev_reorder #(.WIDTH(W), .N(N), .LOG2N(LG)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // scoreboard state
    logic [W:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int first_valid_cyc = -1;
    int first_pop_cyc   = 0;
    int last_pop_cyc    = 0;
    int pop_cnt   = 0;
    int stall_cnt = 0;
    int acc_cyc   = 0;
    bit rand_ready  = 1'b0;
    bit ready_fixed = 1'b0;

    function automatic int bitrev(input int x);
        int r = 0;
        for (int i = 0; i < LG; i++) begin
            if (((x >> i) & 1) != 0) r = r | (1 << (LG - 1 - i));
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: every presented output must match the head of the expected queue
    always @(negedge clk) begin
        if (rstn && out_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got last=%0b data=%0h, expected nothing", out_last, out_data);
            end else if ({out_last, out_data} !== exp_q[0]) begin
                n_fail++;
                $display("FAIL out_sample: got last=%0b data=%0h, expected last=%0b data=%0h",
                         out_last, out_data, exp_q[0][W], exp_q[0][W-1:0]);
            end
            if (out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                pop_cnt++;
                if (pop_cnt == 1) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
            end
        end
    end

    // downstream ready driver
    always @(posedge clk) begin
        #2;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    // driver tasks
    task automatic send_sample(input logic [W-1:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && t < 500) begin
            stall_cnt++;
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected 1", t);
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit ramp, input int idle_pct, input bit push);
        logic [W-1:0] f[N];
        for (int k = 0; k < N; k++) f[k] = ramp ? W'(k) : W'($urandom);
        if (push) for (int k = 0; k < N; k++) exp_q.push_back({(k == N - 1), f[k]});
        for (int p = 0; p < N; p++) begin
            while ($urandom_range(0, 99) < idle_pct) begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
                @(posedge clk);
                #1;
            end
            send_sample(f[bitrev(p)]);
        end
    endtask

    task automatic send_partial(input int count);
        for (int p = 0; p < count; p++) send_sample(W'($urandom));
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() > 0 && t < 8000) begin
            @(negedge clk);
            t++;
        end
        check(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_last", out_last, 0);
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        ready_fixed = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // single ramp frame: natural order, latency 2
        first_valid_cyc = -1;
        pop_cnt = 0;
        send_frame(1'b1, 0, 1'b1);
        in_valid = 1'b0;
        wait_drain("single_drain");
        check("single_latency", first_valid_cyc - acc_cyc, 2);
        check("single_count", pop_cnt, N);
        check("single_contiguous", last_pop_cyc - first_pop_cyc, N - 1);

        // back-to-back frames: no stalls in, no bubbles out
        pop_cnt = 0;
        stall_cnt = 0;
        for (int f = 0; f < 4; f++) send_frame(1'b0, 0, 1'b1);
        in_valid = 1'b0;
        wait_drain("b2b_drain");
        check("b2b_in_stalls", stall_cnt, 0);
        check("b2b_count", pop_cnt, 4 * N);
        check("b2b_contiguous", last_pop_cyc - first_pop_cyc, 4 * N - 1);

        // backpressure: two frames load while downstream is stalled
        ready_fixed = 1'b0;
        @(posedge clk);
        #3;
        stall_cnt = 0;
        send_frame(1'b0, 0, 1'b1);
        send_frame(1'b0, 0, 1'b1);
        in_valid = 1'b0;
        check("bp_in_stalls", stall_cnt, 0);
        @(negedge clk);
        check("bp_both_full_in_ready", in_ready, 0);
        check("bp_out_valid_held", out_valid, 1);
        repeat (5) @(negedge clk);
        check("bp_still_full", in_ready, 0);
        @(posedge clk);
        #1;
        ready_fixed = 1'b1;
        pop_cnt = 0;
        begin
            int t = 0;
            @(negedge clk);
            while (!in_ready && t < 100) begin
                t++;
                @(negedge clk);
            end
            // one cycle after the final issue of the first buffered frame
            check("bp_in_ready_rise", t, N - 1);
        end
        wait_drain("bp_drain");
        check("bp_count", pop_cnt, 2 * N);

        // random stalls on both sides over 100 frames
        rand_ready = 1'b1;
        pop_cnt = 0;
        for (int f = 0; f < 100; f++) send_frame(1'b0, 50, 1'b1);
        in_valid = 1'b0;
        wait_drain("rand_drain");
        check("rand_count", pop_cnt, 100 * N);
        rand_ready = 1'b0;
        ready_fixed = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // reset while frame 0 drains and frame 1 is partially loaded
        send_frame(1'b0, 0, 1'b1);
        send_partial(7);
        in_valid = 1'b0;
        check("rst_pre_out_valid", out_valid, 1);
        #1 rstn = 1'b0;
        exp_q.delete();
        #1;
        check("rst_out_valid_drop", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;
        pop_cnt = 0;
        send_frame(1'b1, 0, 1'b1);
        in_valid = 1'b0;
        wait_drain("rst_new_frame_drain");
        check("rst_new_frame_count", pop_cnt, N);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
